// File: rtl/rect_drop_ctl.sv
// rect_drop_ctl: mouse-driven rectangle position with a gravity drop on left click.
// Idle tracks the mouse; a click drops the rectangle with constant acceleration
// until it reaches the floor, where it parks until the next click.
// Optional feature macro: BOUNCE_EN (floor hits bounce with halved velocity).
module rect_drop_ctl #(
   parameter int unsigned SCREEN_H = 600,
   parameter int unsigned RECT_H   = 64,
   parameter int unsigned TICK_DIV = 400000,
   parameter int unsigned ACCEL    = 1,
   parameter int unsigned VMAX     = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mouse_left,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        busy
);

   localparam int unsigned W  = 12;
   localparam int unsigned YW = W + 1;
   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [YW-1:0] FLOOR   = YW'(SCREEN_H - RECT_H);
   localparam logic [W-1:0]  FLOOR_Y = W'(SCREEN_H - RECT_H);

`ifdef BOUNCE_EN
   typedef enum logic [1:0] {IDLE, FALL, LANDED, RISE} state_t;
`else
   typedef enum logic [1:0] {IDLE, FALL, LANDED} state_t;
`endif

   state_t          state, state_nxt;
   logic [W-1:0]    vel, vel_nxt;
   logic [CW-1:0]   tick_cnt, cnt_nxt;
   logic            mouse_left_d;
   logic [W-1:0]    x_nxt, y_nxt;
   logic            busy_nxt;

   logic            click;
   logic            tick;
   logic [YW-1:0]   v_inc;
   logic [W-1:0]    v_new;
   logic [YW-1:0]   y_sum;
`ifdef BOUNCE_EN
   logic [W-1:0]    v_half;
`endif

   // State, physics and position registers; reset overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         vel          <= '0;
         tick_cnt     <= '0;
         mouse_left_d <= 1'b0;
         xpos         <= '0;
         ypos         <= '0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         vel          <= vel_nxt;
         tick_cnt     <= cnt_nxt;
         mouse_left_d <= mouse_left;
         xpos         <= x_nxt;
         ypos         <= y_nxt;
         busy         <= busy_nxt;
      end
   end

   // Next-state, velocity integration and position update
   always_comb begin
      click     = mouse_left & ~mouse_left_d;
      tick      = (tick_cnt == CW'(TICK_DIV - 1));
      v_inc     = {1'b0, vel} + YW'(ACCEL);
      v_new     = (v_inc >= YW'(VMAX)) ? W'(VMAX) : v_inc[W-1:0];
      y_sum     = {1'b0, ypos} + {1'b0, v_new};
`ifdef BOUNCE_EN
      v_half    = v_new >> 1;
`endif
      state_nxt = state;
      vel_nxt   = vel;
      x_nxt     = xpos;
      y_nxt     = ypos;
      cnt_nxt   = tick ? '0 : tick_cnt + CW'(1);

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            x_nxt   = mouse_xpos;
            y_nxt   = ({1'b0, mouse_ypos} >= FLOOR) ? FLOOR_Y : mouse_ypos;
            if (click) begin
               state_nxt = FALL;
               vel_nxt   = '0;
            end
         end
         FALL: begin
            if (tick) begin
               vel_nxt = v_new;
               if (y_sum >= FLOOR) begin
                  y_nxt = FLOOR_Y;
`ifdef BOUNCE_EN
                  vel_nxt   = v_half;
                  state_nxt = (v_half == '0) ? LANDED : RISE;
`else
                  state_nxt = LANDED;
`endif
               end else begin
                  y_nxt = y_sum[W-1:0];
               end
            end
         end
         LANDED: begin
            cnt_nxt = '0;
            if (click) state_nxt = IDLE;
         end
`ifdef BOUNCE_EN
         RISE: begin
            if (tick) begin
               if (vel <= W'(ACCEL)) begin
                  vel_nxt   = '0;
                  state_nxt = FALL;
               end else begin
                  vel_nxt = vel - W'(ACCEL);
                  y_nxt   = (ypos > vel) ? ypos - vel : '0;
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase

      // Every state entry restarts the physics tick divider
      if (state_nxt != state) cnt_nxt = '0;

`ifdef BOUNCE_EN
      busy_nxt = (state_nxt == FALL) || (state_nxt == RISE);
`else
      busy_nxt = (state_nxt == FALL);
`endif
   end

endmodule

// File: tb/tb_rect_drop_ctl.sv
// tb_rect_drop_ctl: directed bench with a cycle-level reference model feeding a
// scoreboard queue, plus constant checks at the key trajectory points.
module tb_rect_drop_ctl;

   localparam int TICK_DIV = 4;
   localparam int ACCEL    = 1;
   localparam int VMAX     = 64;
   localparam int FLOOR    = 600 - 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mouse_left = 1'b0;
   logic [11:0] mouse_xpos = '0;
   logic [11:0] mouse_ypos = '0;
   logic [11:0] xpos, ypos;
   logic        busy;

   rect_drop_ctl #(
      .SCREEN_H(600), .RECT_H(64), .TICK_DIV(TICK_DIV), .ACCEL(ACCEL), .VMAX(VMAX)
   ) dut (
      .clk(clk), .rst(rst), .mouse_left(mouse_left),
      .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
      .xpos(xpos), .ypos(ypos), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { int x; int y; int b; } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state: 0 idle, 1 fall, 2 landed, 3 rise
   int m_st = 0, m_vel = 0, m_cnt = 0, m_x = 0, m_y = 0, m_b = 0;
   bit m_mld = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input int expv);
      n_checks++;
      assert (obs === 32'(expv)) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
   endtask

   task automatic model(input bit r, input bit ml, input int mx, input int my);
      int nst, nvel, ncnt, ny, vn, ys;
      bit clk_ev, tk;
      if (r) begin
         m_st = 0; m_vel = 0; m_cnt = 0; m_x = 0; m_y = 0; m_b = 0; m_mld = 1'b0;
         return;
      end
      clk_ev = ml && !m_mld;
      tk     = (m_cnt == TICK_DIV - 1);
      nst = m_st; nvel = m_vel; ny = m_y;
      ncnt = tk ? 0 : m_cnt + 1;
      case (m_st)
         0: begin
            m_x = mx;
            ny  = (my > FLOOR) ? FLOOR : my;
            if (clk_ev) begin nst = 1; nvel = 0; end
         end
         1: if (tk) begin
            vn = m_vel + ACCEL;
            if (vn > VMAX) vn = VMAX;
            nvel = vn;
            ys = m_y + vn;
            if (ys >= FLOOR) begin
               ny = FLOOR;
`ifdef BOUNCE_EN
               nvel = vn / 2;
               nst  = (nvel == 0) ? 2 : 3;
`else
               nst  = 2;
`endif
            end else ny = ys;
         end
         2: if (clk_ev) nst = 0;
         default: if (tk) begin
            if (m_vel <= ACCEL) begin nvel = 0; nst = 1; end
            else begin
               ny   = (m_y > m_vel) ? m_y - m_vel : 0;
               nvel = m_vel - ACCEL;
            end
         end
      endcase
      if (nst != m_st || nst == 0 || nst == 2) ncnt = 0;
      m_st = nst; m_vel = nvel; m_cnt = ncnt; m_y = ny; m_mld = ml;
      m_b = (nst == 1 || nst == 3) ? 1 : 0;
   endtask

   // drive one cycle, push model expectation, compare after the edge
   task automatic step(input bit r, input bit ml, input int mx, input int my);
      exp_t e;
      rst = r; mouse_left = ml;
      mouse_xpos = 12'(mx); mouse_ypos = 12'(my);
      model(r, ml, mx, my);
      e.x = m_x; e.y = m_y; e.b = m_b;
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk("sb_x", 32'(xpos), e.x);
      chk("sb_y", 32'(ypos), e.y);
      chk("sb_busy", 32'(busy), e.b);
   endtask

   int exp_y[5] = '{11, 13, 16, 20, 25};
   int rises;
   bit prev_b;

   initial begin
      // power-on reset
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("rst_x", 32'(xpos), 0);
      chk("rst_y", 32'(ypos), 0);
      chk("rst_busy", 32'(busy), 0);

      // 1: reset mid-stream, then tracking resumes
      step(0, 0, 123, 45);
      step(0, 0, 321, 54);
      chk("t1_pre_x", 32'(xpos), 321);
      for (int i = 0; i < 3; i++) step(1, 0, 77, 88);
      chk("t1_rst_x", 32'(xpos), 0);
      chk("t1_rst_y", 32'(ypos), 0);
      chk("t1_rst_busy", 32'(busy), 0);
      step(0, 0, 10, 10);
      chk("t1_x", 32'(xpos), 10);
      chk("t1_y", 32'(ypos), 10);

      // 2: floor clamp while tracking
      step(0, 0, 799, 1000);
      chk("t2_x", 32'(xpos), 799);
      chk("t2_y", 32'(ypos), 536);
      chk("t2_busy", 32'(busy), 0);
      step(0, 0, 1, 536);
      chk("t2_y_eq", 32'(ypos), 536);
      step(0, 0, 1, 535);
      chk("t2_y_lt", 32'(ypos), 535);

      // click at/below floor lands on the first tick
      step(0, 1, 5, 900);
      chk("fl_busy0", 32'(busy), 1);
      for (int i = 0; i < 3; i++) step(0, 0, 6, 7);
      chk("fl_busy3", 32'(busy), 1);
      step(0, 0, 6, 7);
      chk("fl_y", 32'(ypos), 536);
      chk("fl_busy", 32'(busy), 0);
      chk("fl_x", 32'(xpos), 5);
      step(0, 1, 6, 7);
      step(0, 0, 10, 10);
      chk("fl_back_y", 32'(ypos), 10);

      // 3: drop from (10,10), ypos per tick, xpos frozen
      step(0, 1, 10, 10);
      chk("t3_busy", 32'(busy), 1);
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 4; i++) step(0, 0, (i % 2) ? 400 : 20, 300);
         chk("t3_y", 32'(ypos), exp_y[k]);
         chk("t3_x", 32'(xpos), 10);
      end

      // 4: continue to floor with ignored clicks
      for (int i = 0; i < 400 && busy; i++) step(0, (i % 10) == 5, 100 + i, 50);
      chk("t4_y", 32'(ypos), 536);
      chk("t4_busy", 32'(busy), 0);
      for (int i = 0; i < 5; i++) step(0, 0, 300, 200);
      chk("t4_land_x", 32'(xpos), 10);
      chk("t4_land_y", 32'(ypos), 536);
      step(0, 1, 300, 200);
      chk("t4_click_y", 32'(ypos), 536);
      step(0, 0, 300, 200);
      chk("t4_trk_x", 32'(xpos), 300);
      chk("t4_trk_y", 32'(ypos), 200);

      // 5: held button gives exactly one drop
      step(0, 0, 50, 500);
      rises = 0; prev_b = busy;
      for (int i = 0; i < 100; i++) begin
         step(0, 1, 50, 500);
         if (busy && !prev_b) rises++;
         prev_b = busy;
      end
      chk("t5_rises", 32'(rises), 1);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_y", 32'(ypos), 536);
      step(0, 0, 50, 500);
      step(0, 1, 20, 30);
      step(0, 0, 20, 30);
      chk("t5_idle_y", 32'(ypos), 30);
      step(0, 1, 20, 30);
      for (int i = 0; i < 12; i++) step(0, 0, 20, 30);
      chk("t5_tick3_y", 32'(ypos), 36);
      step(1, 0, 20, 30);
      chk("t5_rst_x", 32'(xpos), 0);
      chk("t5_rst_y", 32'(ypos), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      step(0, 0, 7, 9);
      chk("t5_after_y", 32'(ypos), 9);

`ifdef BOUNCE_EN
      // 6: bounce sequence from ypos 500
      step(0, 0, 40, 500);
      step(0, 1, 40, 500);
      rises = 0; prev_b = 1'b0;
      for (int i = 0; i < 2000 && busy; i++) begin
         step(0, 0, 40, 500);
         if (32'(ypos) < 536 && prev_b) rises++;
         prev_b = (ypos == 12'd536);
      end
      chk("t6_bounced", 32'(rises > 0), 1);
      chk("t6_y", 32'(ypos), 536);
      chk("t6_busy", 32'(busy), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
